// File: rtl/wb_arb_2m1s.sv
// Two-master, one-slave arbiter for pipelined Wishbone B4 (STALL) with outstanding-transfer tracking.
// Ownership only changes through IDLE, so WB_S_CYC_OUT is low for at least one cycle between owners.
module wb_arb_2m1s #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIXED_PRIORITY  = 0
) (
    input  logic        CLK,
    input  logic        RST_ASYNC,

    input  logic [31:0] WB_M0_ADR_IN,
    input  logic        WB_M0_CYC_IN,
    input  logic        WB_M0_STB_IN,
    input  logic        WB_M0_WE_IN,
    input  logic [3:0]  WB_M0_SEL_IN,
    input  logic [2:0]  WB_M0_CTI_IN,
    input  logic [1:0]  WB_M0_BTE_IN,
    input  logic [31:0] WB_M0_DAT_WR_IN,
    output logic        WB_M0_STALL_OUT,
    output logic        WB_M0_ACK_OUT,
    output logic        WB_M0_ERR_OUT,
    output logic [31:0] WB_M0_DAT_RD_OUT,

    input  logic [31:0] WB_M1_ADR_IN,
    input  logic        WB_M1_CYC_IN,
    input  logic        WB_M1_STB_IN,
    input  logic        WB_M1_WE_IN,
    input  logic [3:0]  WB_M1_SEL_IN,
    input  logic [2:0]  WB_M1_CTI_IN,
    input  logic [1:0]  WB_M1_BTE_IN,
    input  logic [31:0] WB_M1_DAT_WR_IN,
    output logic        WB_M1_STALL_OUT,
    output logic        WB_M1_ACK_OUT,
    output logic        WB_M1_ERR_OUT,
    output logic [31:0] WB_M1_DAT_RD_OUT,

    output logic [31:0] WB_S_ADR_OUT,
    output logic        WB_S_CYC_OUT,
    output logic        WB_S_STB_OUT,
    output logic        WB_S_WE_OUT,
    output logic [3:0]  WB_S_SEL_OUT,
    output logic [2:0]  WB_S_CTI_OUT,
    output logic [1:0]  WB_S_BTE_OUT,
    output logic [31:0] WB_S_DAT_WR_OUT,
    input  logic        WB_S_STALL_IN,
    input  logic        WB_S_ACK_IN,
    input  logic        WB_S_ERR_IN,
    input  logic [31:0] WB_S_DAT_RD_IN,

    output logic [1:0]  GNT_OUT
);

    localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  MAX_OUT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]  ONE     = CW'(1);

    // Encoding doubles as the one-hot grant vector {M1,M0}.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GNT_M0 = 2'b01,
        ST_GNT_M1 = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic            rr_last_m1_q, rr_last_m1_d;
    logic [CW-1:0]   outst_q, outst_d;

    logic            gnt_m0, gnt_m1;
    logic            accept, resp_ok;

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            state_q      <= ST_IDLE;
            rr_last_m1_q <= 1'b1;
            outst_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_last_m1_q <= rr_last_m1_d;
            outst_q      <= outst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_last_m1_d = rr_last_m1_q;
        case (state_q)
            ST_IDLE: begin
                if (WB_M0_CYC_IN && WB_M1_CYC_IN)
                    state_d = ((FIXED_PRIORITY != 0) || rr_last_m1_q) ? ST_GNT_M0 : ST_GNT_M1;
                else if (WB_M0_CYC_IN)
                    state_d = ST_GNT_M0;
                else if (WB_M1_CYC_IN)
                    state_d = ST_GNT_M1;
            end
            ST_GNT_M0: begin
                if (!WB_M0_CYC_IN) begin
                    state_d      = ST_IDLE;
                    rr_last_m1_d = 1'b0;
                end
            end
            ST_GNT_M1: begin
                if (!WB_M1_CYC_IN) begin
                    state_d      = ST_IDLE;
                    rr_last_m1_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Dropping CYC (release or abort) clears the count, so late responses are discarded.
    always_comb begin
        outst_d = outst_q;
        if (!WB_S_CYC_OUT) begin
            outst_d = '0;
        end else if (accept && !resp_ok) begin
            outst_d = outst_q + ONE;
        end else if (!accept && resp_ok) begin
            outst_d = outst_q - ONE;
        end
    end

    assign gnt_m0  = (state_q == ST_GNT_M0);
    assign gnt_m1  = (state_q == ST_GNT_M1);
    assign accept  = WB_S_STB_OUT && !WB_S_STALL_IN;
    assign resp_ok = (WB_S_ACK_IN || WB_S_ERR_IN) && (outst_q != '0);

    always_comb begin
        WB_S_ADR_OUT    = '0;
        WB_S_CYC_OUT    = 1'b0;
        WB_S_STB_OUT    = 1'b0;
        WB_S_WE_OUT     = 1'b0;
        WB_S_SEL_OUT    = '0;
        WB_S_CTI_OUT    = '0;
        WB_S_BTE_OUT    = '0;
        WB_S_DAT_WR_OUT = '0;
        WB_M0_STALL_OUT = 1'b1;
        WB_M0_ACK_OUT   = 1'b0;
        WB_M0_ERR_OUT   = 1'b0;
        WB_M1_STALL_OUT = 1'b1;
        WB_M1_ACK_OUT   = 1'b0;
        WB_M1_ERR_OUT   = 1'b0;
        if (gnt_m0) begin
            WB_S_ADR_OUT    = WB_M0_ADR_IN;
            WB_S_CYC_OUT    = WB_M0_CYC_IN;
            WB_S_STB_OUT    = WB_M0_STB_IN && WB_M0_CYC_IN && (outst_q < MAX_OUT);
            WB_S_WE_OUT     = WB_M0_WE_IN;
            WB_S_SEL_OUT    = WB_M0_SEL_IN;
            WB_S_CTI_OUT    = WB_M0_CTI_IN;
            WB_S_BTE_OUT    = WB_M0_BTE_IN;
            WB_S_DAT_WR_OUT = WB_M0_DAT_WR_IN;
            WB_M0_STALL_OUT = WB_S_STALL_IN || (outst_q == MAX_OUT);
            WB_M0_ACK_OUT   = WB_S_ACK_IN && (outst_q != '0);
            WB_M0_ERR_OUT   = WB_S_ERR_IN && (outst_q != '0);
        end else if (gnt_m1) begin
            WB_S_ADR_OUT    = WB_M1_ADR_IN;
            WB_S_CYC_OUT    = WB_M1_CYC_IN;
            WB_S_STB_OUT    = WB_M1_STB_IN && WB_M1_CYC_IN && (outst_q < MAX_OUT);
            WB_S_WE_OUT     = WB_M1_WE_IN;
            WB_S_SEL_OUT    = WB_M1_SEL_IN;
            WB_S_CTI_OUT    = WB_M1_CTI_IN;
            WB_S_BTE_OUT    = WB_M1_BTE_IN;
            WB_S_DAT_WR_OUT = WB_M1_DAT_WR_IN;
            WB_M1_STALL_OUT = WB_S_STALL_IN || (outst_q == MAX_OUT);
            WB_M1_ACK_OUT   = WB_S_ACK_IN && (outst_q != '0);
            WB_M1_ERR_OUT   = WB_S_ERR_IN && (outst_q != '0);
        end
    end

    assign WB_M0_DAT_RD_OUT = WB_S_DAT_RD_IN;
    assign WB_M1_DAT_RD_OUT = WB_S_DAT_RD_IN;
    assign GNT_OUT          = state_q;

endmodule

// File: tb/tb_wb_arb_2m1s.sv
// Bench for wb_arb_2m1s: round-robin instance driven by a vector table and hand sequences,
// plus a fixed-priority instance sharing the same inputs.
module tb_wb_arb_2m1s;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m0_adr = '0, m1_adr = '0, m0_dwr = '0, m1_dwr = '0, s_drd = '0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [3:0]  m0_sel = '0, m1_sel = '0;
    logic [2:0]  m0_cti = '0, m1_cti = '0;
    logic [1:0]  m0_bte = '0, m1_bte = '0;
    logic        s_stall = 0, s_ack = 0, s_err = 0;

    logic        m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
    logic [31:0] m0_drd, m1_drd, s_adr, s_dwr;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte, gnt;

    logic        f_m0_stall, f_m0_ack, f_m0_err, f_m1_stall, f_m1_ack, f_m1_err;
    logic [31:0] f_m0_drd, f_m1_drd, f_s_adr, f_s_dwr;
    logic        f_s_cyc, f_s_stb, f_s_we;
    logic [3:0]  f_s_sel;
    logic [2:0]  f_s_cti;
    logic [1:0]  f_s_bte, f_gnt;

    wb_arb_2m1s #(.MAX_OUTSTANDING(4), .FIXED_PRIORITY(0)) u_dut (
        .CLK(clk), .RST_ASYNC(rst),
        .WB_M0_ADR_IN(m0_adr), .WB_M0_CYC_IN(m0_cyc), .WB_M0_STB_IN(m0_stb), .WB_M0_WE_IN(m0_we),
        .WB_M0_SEL_IN(m0_sel), .WB_M0_CTI_IN(m0_cti), .WB_M0_BTE_IN(m0_bte), .WB_M0_DAT_WR_IN(m0_dwr),
        .WB_M0_STALL_OUT(m0_stall), .WB_M0_ACK_OUT(m0_ack), .WB_M0_ERR_OUT(m0_err), .WB_M0_DAT_RD_OUT(m0_drd),
        .WB_M1_ADR_IN(m1_adr), .WB_M1_CYC_IN(m1_cyc), .WB_M1_STB_IN(m1_stb), .WB_M1_WE_IN(m1_we),
        .WB_M1_SEL_IN(m1_sel), .WB_M1_CTI_IN(m1_cti), .WB_M1_BTE_IN(m1_bte), .WB_M1_DAT_WR_IN(m1_dwr),
        .WB_M1_STALL_OUT(m1_stall), .WB_M1_ACK_OUT(m1_ack), .WB_M1_ERR_OUT(m1_err), .WB_M1_DAT_RD_OUT(m1_drd),
        .WB_S_ADR_OUT(s_adr), .WB_S_CYC_OUT(s_cyc), .WB_S_STB_OUT(s_stb), .WB_S_WE_OUT(s_we),
        .WB_S_SEL_OUT(s_sel), .WB_S_CTI_OUT(s_cti), .WB_S_BTE_OUT(s_bte), .WB_S_DAT_WR_OUT(s_dwr),
        .WB_S_STALL_IN(s_stall), .WB_S_ACK_IN(s_ack), .WB_S_ERR_IN(s_err), .WB_S_DAT_RD_IN(s_drd),
        .GNT_OUT(gnt)
    );

    wb_arb_2m1s #(.MAX_OUTSTANDING(4), .FIXED_PRIORITY(1)) u_fix (
        .CLK(clk), .RST_ASYNC(rst),
        .WB_M0_ADR_IN(m0_adr), .WB_M0_CYC_IN(m0_cyc), .WB_M0_STB_IN(m0_stb), .WB_M0_WE_IN(m0_we),
        .WB_M0_SEL_IN(m0_sel), .WB_M0_CTI_IN(m0_cti), .WB_M0_BTE_IN(m0_bte), .WB_M0_DAT_WR_IN(m0_dwr),
        .WB_M0_STALL_OUT(f_m0_stall), .WB_M0_ACK_OUT(f_m0_ack), .WB_M0_ERR_OUT(f_m0_err), .WB_M0_DAT_RD_OUT(f_m0_drd),
        .WB_M1_ADR_IN(m1_adr), .WB_M1_CYC_IN(m1_cyc), .WB_M1_STB_IN(m1_stb), .WB_M1_WE_IN(m1_we),
        .WB_M1_SEL_IN(m1_sel), .WB_M1_CTI_IN(m1_cti), .WB_M1_BTE_IN(m1_bte), .WB_M1_DAT_WR_IN(m1_dwr),
        .WB_M1_STALL_OUT(f_m1_stall), .WB_M1_ACK_OUT(f_m1_ack), .WB_M1_ERR_OUT(f_m1_err), .WB_M1_DAT_RD_OUT(f_m1_drd),
        .WB_S_ADR_OUT(f_s_adr), .WB_S_CYC_OUT(f_s_cyc), .WB_S_STB_OUT(f_s_stb), .WB_S_WE_OUT(f_s_we),
        .WB_S_SEL_OUT(f_s_sel), .WB_S_CTI_OUT(f_s_cti), .WB_S_BTE_OUT(f_s_bte), .WB_S_DAT_WR_OUT(f_s_dwr),
        .WB_S_STALL_IN(s_stall), .WB_S_ACK_IN(s_ack), .WB_S_ERR_IN(s_err), .WB_S_DAT_RD_IN(s_drd),
        .GNT_OUT(f_gnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        s_stall = 0; s_ack = 0; s_err = 0; s_drd = '0;
    endtask

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    // in  = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_stall, s_ack}
    // exp = {gnt[1:0], s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack}
    typedef struct packed {
        logic [5:0] in;
        logic [7:0] exp;
    } vec_t;

    vec_t        vecs[21];
    logic [31:0] exp_q[$];
    logic [31:0] slv_q[$];
    logic [31:0] exp_adr, got;
    int          issued, resp_cnt, outst_m;
    logic        exp_sstb, resp, is_err;

    initial begin
        vecs[0]  = '{6'b000000, 8'b00_0_0_1_1_0_0};
        vecs[1]  = '{6'b111100, 8'b00_0_0_1_1_0_0};
        vecs[2]  = '{6'b111100, 8'b01_1_1_0_1_0_0};
        vecs[3]  = '{6'b101101, 8'b01_1_0_0_1_1_0};
        vecs[4]  = '{6'b001100, 8'b01_0_0_0_1_0_0};
        vecs[5]  = '{6'b001100, 8'b00_0_0_1_1_0_0};
        vecs[6]  = '{6'b001100, 8'b10_1_1_1_0_0_0};
        vecs[7]  = '{6'b001001, 8'b10_1_0_1_0_0_1};
        vecs[8]  = '{6'b110000, 8'b10_0_0_1_0_0_0};
        vecs[9]  = '{6'b111100, 8'b00_0_0_1_1_0_0};
        vecs[10] = '{6'b111100, 8'b01_1_1_0_1_0_0};
        vecs[11] = '{6'b001100, 8'b01_0_0_0_1_0_0};
        vecs[12] = '{6'b001101, 8'b00_0_0_1_1_0_0};
        vecs[13] = '{6'b001101, 8'b10_1_1_1_0_0_0};
        vecs[14] = '{6'b000000, 8'b10_0_0_1_0_0_0};
        vecs[15] = '{6'b000000, 8'b00_0_0_1_1_0_0};
        vecs[16] = '{6'b110000, 8'b00_0_0_1_1_0_0};
        vecs[17] = '{6'b110010, 8'b01_1_1_1_1_0_0};
        vecs[18] = '{6'b100001, 8'b01_1_0_0_1_0_0};
        vecs[19] = '{6'b000000, 8'b01_0_0_0_1_0_0};
        vecs[20] = '{6'b000000, 8'b00_0_0_1_1_0_0};

        // reset state
        #3;
        check("reset gnt/stall/ack", {gnt, s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack}, 8'b00_0_0_1_1_0_0);
        check("reset s_adr", s_adr, 0);
        #9 rst = 0;

        // table: contention, round-robin, release, abort, stall, zero-outstanding response
        m0_we = 1; m0_sel = 4'hF; m1_we = 0; m1_sel = 4'h3;
        for (int i = 0; i < 21; i++) begin
            tick();
            {m0_cyc, m0_stb, m1_cyc, m1_stb, s_stall, s_ack} = vecs[i].in;
            m0_adr = 32'h1000_0000 + i;
            m1_adr = 32'h2000_0000 + i;
            #2;
            check($sformatf("vec%0d ctl", i), {gnt, s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack}, vecs[i].exp);
            exp_adr = (vecs[i].exp[7:6] == 2'b01) ? m0_adr : (vecs[i].exp[7:6] == 2'b10) ? m1_adr : 32'h0;
            check($sformatf("vec%0d mux", i), {s_adr, s_we, s_sel},
                  {exp_adr, vecs[i].exp[7:6] == 2'b01, (vecs[i].exp[7:6] == 2'b01) ? 4'hF :
                   (vecs[i].exp[7:6] == 2'b10) ? 4'h3 : 4'h0});
        end
        clr();

        // single M0 read of 0x1FC00000, slave answers two cycles after acceptance
        tick(); m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h1FC0_0000; #2;
        check("rd gnt idle", gnt, 2'b00);
        tick(); #2;
        check("rd gnt", gnt, 2'b01);
        check("rd s_adr", s_adr, 32'h1FC0_0000);
        check("rd s_stb", s_stb, 1);
        if (s_stb && !s_stall) exp_q.push_back(32'hDEAD_BEEF);
        tick(); m0_stb = 0; #2;
        check("rd no early ack", m0_ack, 0);
        tick(); s_ack = 1; s_drd = 32'hDEAD_BEEF; #2;
        check("rd ack", {m0_ack, m1_ack}, 2'b10);
        if (m0_ack && exp_q.size() > 0) check("rd data", m0_drd, exp_q.pop_front());
        tick(); s_ack = 0; m0_cyc = 0; #2;
        check("rd cyc drop", s_cyc, 0);
        tick(); #2;
        check("rd idle", gnt, 2'b00);
        check("rd queue empty", exp_q.size(), 0);

        // six pipelined reads, responses held back: outstanding limit at 4
        issued = 0; resp_cnt = 0; outst_m = 0;
        for (int k = 0; k < 40 && resp_cnt < 6; k++) begin
            tick();
            m0_cyc = 1;
            m0_stb = (issued < 6);
            m0_adr = 32'h8000_0000 + 32'(issued * 4);
            resp   = (k >= 7) && (slv_q.size() > 0);
            is_err = resp && (resp_cnt == 5);
            s_ack  = resp && !is_err;
            s_err  = is_err;
            s_drd  = resp ? dfun(slv_q[0]) : 32'h0;
            #2;
            exp_sstb = (k >= 1) && m0_stb && (outst_m < 4);
            check($sformatf("pipe%0d stb", k), s_stb, exp_sstb);
            check($sformatf("pipe%0d stall", k), m0_stall, (k < 1) || (outst_m == 4));
            if (exp_sstb) begin
                slv_q.push_back(s_adr);
                exp_q.push_back(dfun(m0_adr));
                issued++;
                outst_m++;
            end
            if (resp) begin
                check($sformatf("pipe resp%0d ack/err", resp_cnt), {m0_ack, m0_err, m1_ack, m1_err},
                      {!is_err, is_err, 2'b00});
                void'(slv_q.pop_front());
                resp_cnt++;
                outst_m--;
            end
            if ((m0_ack || m0_err) && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                check($sformatf("pipe resp%0d data", resp_cnt - 1), m0_drd, got);
            end
        end
        check("pipe responses", resp_cnt, 6);
        check("pipe queue empty", exp_q.size(), 0);
        tick(); clr(); tick(); #2;
        check("pipe idle", gnt, 2'b00);
        exp_q.delete(); slv_q.delete();

        // M1 aborts with two outstanding; late ACKs reach nobody; M0 then starts from zero
        tick(); m1_cyc = 1; m1_stb = 1; #2;
        tick(); #2;
        check("abort gnt m1", gnt, 2'b10);
        tick(); #2;
        tick(); m1_cyc = 0; m1_stb = 0; m0_cyc = 1; m0_stb = 0; #2;
        check("abort cyc drop", {s_cyc, gnt}, 3'b0_10);
        tick(); s_ack = 1; #2;
        check("abort late ack 1", {gnt, m0_ack, m1_ack}, 4'b00_0_0);
        tick(); #2;
        check("abort late ack 2", {gnt, m0_ack, m1_ack}, 4'b01_0_0);
        tick(); s_ack = 0; m0_stb = 1; #2;
        tick(); m0_stb = 0; s_ack = 1; #2;
        check("abort m0 fresh ack", m0_ack, 1);
        tick(); clr(); tick(); tick(); #2;
        check("abort idle", gnt, 2'b00);

        // fixed priority: M1 only wins in windows where M0 CYC is low
        begin
            logic [1:0] fc0[12] = '{1, 1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0};
            logic [1:0] fc1[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
            logic [1:0] fg[12]  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01,
                                    2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
            for (int k = 0; k < 12; k++) begin
                tick();
                m0_cyc = fc0[k][0]; m1_cyc = fc1[k][0];
                #2;
                check($sformatf("fixed%0d gnt", k), f_gnt, fg[k]);
            end
        end
        clr(); tick(); tick();

        // async reset mid-burst, between clock edges
        tick(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4000_0000; #2;
        tick(); #2;
        tick(); #2;
        check("rst pre gnt", gnt, 2'b01);
        s_ack = 1;
        rst = 1; #1;
        check("rst async ctl", {gnt, s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m0_err, m1_ack},
              9'b00_0_0_1_1_0_0_0);
        check("rst async adr", s_adr, 0);
        clr();
        #3 rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick(); #2;
            check($sformatf("post rst quiet%0d", k), {gnt, s_cyc, s_stb}, 4'b0);
        end
        tick(); m0_cyc = 1; #2;
        tick(); s_ack = 1; #2;
        check("post rst gnt", gnt, 2'b01);
        check("post rst stale ack", m0_ack, 0);
        tick(); clr(); #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
